// File: rtl/vga_rect_fill_if.sv
// Fill command channel and frame-buffer write port of vga_rect_fill.
// master: command source and memory side; slave: the fill engine.
interface vga_rect_fill_if #(
  parameter int data_width = 3,
  parameter int h_width    = 10,
  parameter int v_width    = 10,
  parameter int addr_width = 19
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [h_width-1:0]    cmd_x0;
  logic [h_width-1:0]    cmd_x1;
  logic [v_width-1:0]    cmd_y0;
  logic [v_width-1:0]    cmd_y1;
  logic [data_width-1:0] cmd_color;
  logic                  wr_en;
  logic [addr_width-1:0] wr_addr;
  logic [data_width-1:0] wr_data;
  logic                  mem_ready;

  modport master (
    output cmd_valid, cmd_x0, cmd_x1,
    output cmd_y0, cmd_y1, cmd_color,
    output mem_ready,
    input  cmd_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_x1,
    input  cmd_y0, cmd_y1, cmd_color,
    input  mem_ready,
    output cmd_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: writes one colour row-major into a frame buffer.
// Ports: clk, rst_n (async low), bus (slave), busy, done, err.
// Define VGA_RECT_FILL_CLIP_EN to clip x1/y1 instead of rejecting.
module vga_rect_fill #(
  parameter int data_width = 3,
  parameter int h_width    = 10,
  parameter int v_width    = 10,
  parameter int horiz      = 640,
  parameter int vert       = 480,
  parameter int addr_width = 19
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_rect_fill_if.slave bus,
  output logic           busy,
  output logic           done,
  output logic           err
);

  typedef enum logic [1:0] {
    IDLE, CHECK, FILL, DONE
  } state_t;

  localparam logic [h_width:0] h_lim =
    horiz[h_width:0];
  localparam logic [v_width:0] v_lim =
    vert[v_width:0];
  localparam logic [addr_width-1:0] h_step =
    addr_width'(horiz);
`ifdef VGA_RECT_FILL_CLIP_EN
  localparam logic [h_width-1:0] x_last =
    h_width'(horiz - 1);
  localparam logic [v_width-1:0] y_last =
    v_width'(vert - 1);
`endif

  state_t                state;
  logic                  cmd_ready;
  logic                  wr_en;
  logic [addr_width-1:0] wr_addr;
  logic [data_width-1:0] wr_data;
  logic [h_width-1:0]    x0_q, x1_q, x;
  logic [v_width-1:0]    y0_q, y1_q, y;
  logic [data_width-1:0] color_q;
  logic [addr_width-1:0] row_base;
  logic [h_width-1:0]    x1_eff;
  logic [v_width-1:0]    y1_eff;
  logic                  reject;

  assign bus.cmd_ready = cmd_ready;
  assign bus.wr_en     = wr_en;
  assign bus.wr_addr   = wr_addr;
  assign bus.wr_data   = wr_data;
  assign busy          = (state != IDLE);

  always_comb begin
    x1_eff = x1_q;
    y1_eff = y1_q;
    reject = 1'b0;
`ifdef VGA_RECT_FILL_CLIP_EN
    if ({1'b0, x1_q} >= h_lim) x1_eff = x_last;
    if ({1'b0, y1_q} >= v_lim) y1_eff = y_last;
`else
    if ({1'b0, x1_q} >= h_lim ||
        {1'b0, y1_q} >= v_lim)
      reject = 1'b1;
`endif
    if (x0_q > x1_eff || y0_q > y1_eff ||
        {1'b0, x0_q} >= h_lim ||
        {1'b0, y0_q} >= v_lim)
      reject = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      x0_q      <= '0;
      x1_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      x         <= '0;
      y         <= '0;
      color_q   <= '0;
      row_base  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready) begin
            x0_q      <= bus.cmd_x0;
            x1_q      <= bus.cmd_x1;
            y0_q      <= bus.cmd_y0;
            y1_q      <= bus.cmd_y1;
            color_q   <= bus.cmd_color;
            cmd_ready <= 1'b0;
            state     <= CHECK;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        CHECK: begin
          if (reject) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            x        <= x0_q;
            y        <= y0_q;
            x1_q     <= x1_eff;
            y1_q     <= y1_eff;
            row_base <= addr_width'(y0_q) * h_step;
            state    <= FILL;
          end
        end
        FILL: begin
          if (!wr_en) begin
            wr_en   <= 1'b1;
            wr_addr <= row_base + addr_width'(x);
            wr_data <= color_q;
          end else if (bus.mem_ready) begin
            // next address is issued straight away so
            // an unstalled fill writes every cycle
            if (x != x1_q) begin
              x       <= x + h_width'(1);
              wr_addr <= wr_addr + addr_width'(1);
            end else if (y != y1_q) begin
              x        <= x0_q;
              y        <= y + v_width'(1);
              row_base <= row_base + h_step;
              wr_addr  <= row_base + h_step +
                          addr_width'(x0_q);
            end else begin
              wr_en <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Randomised self-checking bench for vga_rect_fill.
// Reference: rectangle expanded to a row-major address list.
module tb_vga_rect_fill;

  localparam int DW = 3;
  localparam int HW = 10;
  localparam int VW = 10;
  localparam int AW = 19;
  localparam int H  = 640;
  localparam int V  = 480;

  logic clk;
  logic rst_n;
  logic busy, done, err;

  vga_rect_fill_if #(
    .data_width(DW), .h_width(HW),
    .v_width(VW), .addr_width(AW)
  ) bus ();

  vga_rect_fill #(
    .data_width(DW), .h_width(HW), .v_width(VW),
    .horiz(H), .vert(V), .addr_width(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  int got_a[$];
  int got_d[$];
  int done_cyc, err_cyc, first_wr, ready_cyc;
  int n_done, n_errp, held, hold_addr;
  bit armed;
  bit stall_p;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p)
        check("stall_hold",
          32'({bus.wr_en, bus.wr_addr, bus.wr_data}),
          32'({1'b1, p_addr, p_data}));
      stall_p = bus.wr_en && !bus.mem_ready;
      p_addr  = bus.wr_addr;
      p_data  = bus.wr_data;
      if (bus.wr_en && bus.mem_ready) begin
        got_a.push_back(int'(bus.wr_addr));
        got_d.push_back(int'(bus.wr_data));
      end
      if (bus.wr_en) begin
        if (first_wr < 0) first_wr = cyc;
        if (int'(bus.wr_addr) == hold_addr) held++;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (err) begin
        n_errp++;
        if (err_cyc < 0) err_cyc = cyc;
      end
      if (armed && bus.cmd_ready && ready_cyc < 0)
        ready_cyc = cyc;
    end
  end

  task automatic clear_rec();
    got_a.delete();
    got_d.delete();
    done_cyc = -1; err_cyc = -1;
    first_wr = -1; ready_cyc = -1;
    n_done = 0; n_errp = 0;
    held = 0; hold_addr = -1;
    armed = 1'b0;
  endtask

  task automatic drive_cmd(input int x0, x1, y0, y1, c);
    bus.cmd_x0    = HW'(x0);
    bus.cmd_x1    = HW'(x1);
    bus.cmd_y0    = VW'(y0);
    bus.cmd_y1    = VW'(y1);
    bus.cmd_color = DW'(c);
  endtask

  // mode 0: mem_ready high, 1: random stalls,
  // 2: three stall cycles on the second write
  task automatic run_cmd(input int x0, x1, y0, y1, c,
                         input int mode, input bit poke);
    int qa[$];
    int x1e, y1e, n, lim, bound, stall;
    bit rej, fin;
    x1e = x1; y1e = y1; rej = 1'b0;
`ifdef VGA_RECT_FILL_CLIP_EN
    if (x1e >= H) x1e = H - 1;
    if (y1e >= V) y1e = V - 1;
`else
    if (x1 >= H || y1 >= V) rej = 1'b1;
`endif
    if (x0 > x1e || y0 > y1e || x0 >= H || y0 >= V)
      rej = 1'b1;
    if (!rej)
      for (int yy = y0; yy <= y1e; yy++)
        for (int xx = x0; xx <= x1e; xx++)
          qa.push_back(yy * H + xx);

    lim = 0;
    while (!bus.cmd_ready && lim < 50) begin
      @(posedge clk); #1; lim++;
    end
    check("cmd_ready_wait", 32'(bus.cmd_ready), 32'(1));
    clear_rec();
    if (qa.size() > 1) hold_addr = qa[1];
    drive_cmd(x0, x1, y0, y1, c);
    bus.cmd_valid = 1'b1;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    n = cyc;
    armed = 1'b1;
    bus.cmd_valid = 1'b0;

    bound = qa.size() * 6 + 40;
    lim = 0; stall = 0; fin = 1'b0;
    while (!fin && lim < bound) begin
      bus.cmd_valid = poke && done_cyc < 0 &&
                      $urandom_range(0, 1) == 1;
      if (bus.cmd_valid)
        drive_cmd(0, 3, 0, 1, $urandom_range(0, 7));
      case (mode)
        1: bus.mem_ready = $urandom_range(0, 3) != 0;
        2: if (got_a.size() == 1 && stall < 3) begin
             bus.mem_ready = 1'b0; stall++;
           end else bus.mem_ready = 1'b1;
        default: bus.mem_ready = 1'b1;
      endcase
      @(posedge clk); #1; lim++;
      fin = (done_cyc >= 0 || err_cyc >= 0) &&
            ready_cyc >= 0;
    end
    bus.cmd_valid = 1'b0;
    bus.mem_ready = 1'b1;
    check("finished", 32'(fin), 32'(1));

    check("n_writes", 32'(got_a.size()), 32'(qa.size()));
    for (int i = 0; i < qa.size() && i < got_a.size(); i++) begin
      check("wr_addr", 32'(got_a[i]), 32'(qa[i]));
      check("wr_data", 32'(got_d[i]), 32'(c & 7));
    end
    check("done_pulses", 32'(n_done), rej ? 0 : 1);
    check("err_pulses", 32'(n_errp), rej ? 1 : 0);
    if (rej) begin
      check("err_cyc", 32'(err_cyc), 32'(n + 1));
      check("ready_cyc", 32'(ready_cyc), 32'(n + 2));
    end else if (mode == 0) begin
      check("first_wr", 32'(first_wr), 32'(n + 2));
      check("done_cyc", 32'(done_cyc),
            32'(n + 2 + qa.size()));
      check("ready_cyc", 32'(ready_cyc),
            32'(n + 3 + qa.size()));
    end
    if (mode == 2 && !rej)
      check("held_cycles", 32'(held), 32'(4));
  endtask

  initial begin
    int x0, x1, y0, y1, lim;
    clear_rec();
    stall_p = 1'b0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.mem_ready = 1'b1;
    drive_cmd(0, 0, 0, 0, 0);
    #3;
    check("rst_wr_en", 32'(bus.wr_en), 32'(0));
    check("rst_ready", 32'(bus.cmd_ready), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_addr", 32'(bus.wr_addr), 32'(0));
    check("rst_data", 32'(bus.wr_data), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(bus.cmd_ready), 32'(1));

    run_cmd(10, 12, 20, 21, 5, 0, 1'b0);
    run_cmd(10, 12, 20, 21, 5, 2, 1'b0);
    run_cmd(5, 4, 0, 0, 3, 0, 1'b0);
    run_cmd(638, 700, 479, 479, 6, 0, 1'b0);
    run_cmd(639, 639, 479, 479, 7, 0, 1'b0);
    run_cmd(0, 0, 0, 0, 1, 0, 1'b0);
    run_cmd(100, 103, 50, 52, 2, 0, 1'b1);

    // reset on the third write of a full-screen fill
    clear_rec();
    drive_cmd(0, H - 1, 0, V - 1, 4);
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    lim = 0;
    while (got_a.size() < 2 && lim < 20) begin
      @(posedge clk); #1; lim++;
    end
    check("third_addr", 32'(bus.wr_addr), 32'(2));
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en", 32'(bus.wr_en), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_ready", 32'(bus.cmd_ready), 32'(0));
    check("mid_rst_addr", 32'(bus.wr_addr), 32'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_ready", 32'(bus.cmd_ready), 32'(1));
    repeat (10) @(posedge clk);
    #1;
    check("no_wr_after_rst", 32'(got_a.size()), 32'(2));
    run_cmd(1, 2, 1, 1, 3, 0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      x0 = $urandom_range(0, H + 20);
      y0 = $urandom_range(0, V + 10);
      x1 = x0 + $urandom_range(0, 7);
      y1 = y0 + $urandom_range(0, 3);
      if ($urandom_range(0, 5) == 0) x1 = x0 - 1;
      if ($urandom_range(0, 5) == 0) y1 = y0 - 1;
      if (x1 < 0) x1 = 0;
      if (y1 < 0) y1 = 0;
      if (x0 > 1023) x0 = 1023;
      if (x1 > 1023) x1 = 1023;
      run_cmd(x0, x1, y0, y1, $urandom_range(0, 7),
              $urandom_range(0, 1), $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
